// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Sequences the write enables of a 5-stage pipeline (PC, IF/ID, ID/EX,
//   EX/MEM, MEM/WB) around hazards.
//     - Holds the front of the pipe and injects bubbles for BOOT_CYC clocks
//       after reset release.
//     - Stalls PC and IF/ID and bubbles ID/EX on a load-use hazard.
//     - Flushes IF/ID on a taken branch.
//     - Freezes the whole pipe while a data-memory access is outstanding.
//     - Raises a sticky error if a memory wait lasts MEM_TMO cycles.
//     - Keeps saturating stall/flush cycle counters.
//
// Parameters:
//   BOOT_CYC  cycles the pipe is held after reset release
//   MEM_TMO   MEM_WAIT cycles before err_o is raised
//   CNT_W     width of the performance counters
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous reset, active low
//   ID_rs1_i        rs1 of the instruction in ID
//   ID_rs2_i        rs2 of the instruction in ID
//   ID_uses_rs2_i   instruction in ID reads rs2
//   EX_rd_i         rd held in ID/EX
//   EX_MemRead_i    MemRead held in ID/EX
//   branch_taken_i  branch in ID resolved taken
//   dmem_req_i      MEM stage has an access in flight
//   dmem_ack_i      data memory completes the access this cycle
//   PCWrite_o       PC update enable
//   IFID_Write_o    IF/ID update enable
//   IFID_Flush_o    IF/ID loads a NOP
//   IDEX_Bubble_o   zero all control fields entering ID/EX
//   pipe_hold_o     EX/MEM and MEM/WB hold their contents
//   err_o           sticky memory timeout flag
//   stall_cnt_o     cycles with PCWrite_o=0, saturating
//   flush_cnt_o     cycles with IFID_Flush_o=1, saturating
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int BOOT_CYC = 2,
    parameter int MEM_TMO  = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic             ID_uses_rs2_i,
    input  logic [4:0]       EX_rd_i,
    input  logic             EX_MemRead_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             pipe_hold_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int BOOT_W = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam int TMO_W  = $clog2(MEM_TMO + 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t            r_state;
    logic [BOOT_W-1:0] r_boot_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_freeze;
    logic w_load_use;

    // The freeze condition is evaluated identically in RUN and MEM_WAIT, so an
    // ack (or a dropped request) releases the pipe in the same cycle it arrives.
    assign w_freeze   = (r_state != ST_BOOT) && dmem_req_i && !dmem_ack_i;
    assign w_load_use = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                        ((EX_rd_i == ID_rs1_i) ||
                         (ID_uses_rs2_i && (EX_rd_i == ID_rs2_i)));

    // Enable decode. A branch that loses to a stall is not recorded anywhere:
    // it stays in ID because IF/ID is held, so it wins once the stall clears.
    always_comb begin
        PCWrite_o     = 1'b1;
        IFID_Write_o  = 1'b1;
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (r_state == ST_BOOT) begin
            PCWrite_o     = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else if (w_freeze) begin
            PCWrite_o     = 1'b0;
            IFID_Write_o  = 1'b0;
            pipe_hold_o   = 1'b1;
        end else if (w_load_use) begin
            PCWrite_o     = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            IFID_Flush_o  = 1'b1;
        end
    end

    // State machine, timeout watchdog and performance counters. The counters
    // sample the decoded enables, so BOOT cycles count as stalls too.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PCWrite_o && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (IFID_Flush_o && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);

            unique case (r_state)
                ST_BOOT: begin
                    if (r_boot_cnt == BOOT_W'(BOOT_CYC - 1))
                        r_state <= ST_RUN;
                    else
                        r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
                end
                ST_RUN: begin
                    if (w_freeze) begin
                        r_state   <= ST_MEM_WAIT;
                        r_tmo_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    // The watchdog only flags; the pipe keeps waiting for the ack.
                    if (r_tmo_cnt != TMO_W'(MEM_TMO))
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    if (r_tmo_cnt == TMO_W'(MEM_TMO - 1))
                        r_err <= 1'b1;
                    if (!dmem_req_i || dmem_ack_i)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign err_o       = r_err;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Directed-vector bench for pipe_hazard_ctrl with a 4-bit counter build so
// saturation is reachable. The driver applies one vector per clock and pushes
// the hand-computed expected outputs for that cycle; the monitor pops and
// compares on the falling edge.
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic [4:0] ID_rs1_i;
    logic [4:0] ID_rs2_i;
    logic       ID_uses_rs2_i;
    logic [4:0] EX_rd_i;
    logic       EX_MemRead_i;
    logic       branch_taken_i;
    logic       dmem_req_i;
    logic       dmem_ack_i;
    logic       PCWrite_o;
    logic       IFID_Write_o;
    logic       IFID_Flush_o;
    logic       IDEX_Bubble_o;
    logic       pipe_hold_o;
    logic       err_o;
    logic [3:0] stall_cnt_o;
    logic [3:0] flush_cnt_o;

    // Enable patterns, packed as {PCWrite, IFID_Write, Flush, Bubble, Hold}
    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] BUB   = 5'b00010;
    localparam logic [4:0] FRZ   = 5'b00001;
    localparam logic [4:0] FLUSH = 5'b11100;

    typedef struct {
        string      name;
        logic [4:0] en;
        logic       err;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t expQ[$];
    int   vecCount = 0;
    int   missCount = 0;

    pipe_hazard_ctrl #(
        .BOOT_CYC(2),
        .MEM_TMO (64),
        .CNT_W   (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ID_rs1_i      (ID_rs1_i),
        .ID_rs2_i      (ID_rs2_i),
        .ID_uses_rs2_i (ID_uses_rs2_i),
        .EX_rd_i       (EX_rd_i),
        .EX_MemRead_i  (EX_MemRead_i),
        .branch_taken_i(branch_taken_i),
        .dmem_req_i    (dmem_req_i),
        .dmem_ack_i    (dmem_ack_i),
        .PCWrite_o     (PCWrite_o),
        .IFID_Write_o  (IFID_Write_o),
        .IFID_Flush_o  (IFID_Flush_o),
        .IDEX_Bubble_o (IDEX_Bubble_o),
        .pipe_hold_o   (pipe_hold_o),
        .err_o         (err_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    // Free-running 10-unit clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Drive one vector just after a rising edge and queue what the DUT should
    // show for the rest of that cycle.
    task automatic applyStimulus(input string name, input logic rst,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic br,
                                 input logic req, input logic ack,
                                 input logic [4:0] en, input logic err,
                                 input logic [3:0] sc, input logic [3:0] fc);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i          = rst;
        ID_rs1_i       = rs1;
        ID_rs2_i       = rs2;
        ID_uses_rs2_i  = u2;
        EX_rd_i        = rd;
        EX_MemRead_i   = mr;
        branch_taken_i = br;
        dmem_req_i     = req;
        dmem_ack_i     = ack;
        e.name = name;
        e.en   = en;
        e.err  = err;
        e.sc   = sc;
        e.fc   = fc;
        expQ.push_back(e);
    endtask

    // Vector with no hazard sources and no memory activity
    task automatic idle(input string name, input logic rst, input logic [4:0] en,
                        input logic err, input logic [3:0] sc, input logic [3:0] fc);
        applyStimulus(name, rst, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0,
                      en, err, sc, fc);
    endtask

    // Memory request pending (or acked) with no hazard sources
    task automatic memVec(input string name, input logic rst, input logic ack,
                          input logic [4:0] en, input logic err,
                          input logic [3:0] sc, input logic [3:0] fc);
        applyStimulus(name, rst, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, ack,
                      en, err, sc, fc);
    endtask

    // Field-by-field comparison of one queued expectation
    task automatic checkOutput(input exp_t e);
        logic [4:0] gotEn;
        gotEn = {PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, pipe_hold_o};
        vecCount++;
        if (gotEn !== e.en) begin
            missCount++;
            $display("[TB] FAIL %s enables {pcw,ifw,flush,bub,hold} got %b expected %b",
                     e.name, gotEn, e.en);
        end
        if (err_o !== e.err) begin
            missCount++;
            $display("[TB] FAIL %s err_o got %b expected %b", e.name, err_o, e.err);
        end
        if (stall_cnt_o !== e.sc) begin
            missCount++;
            $display("[TB] FAIL %s stall_cnt_o got %0d expected %0d", e.name, stall_cnt_o, e.sc);
        end
        if (flush_cnt_o !== e.fc) begin
            missCount++;
            $display("[TB] FAIL %s flush_cnt_o got %0d expected %0d", e.name, flush_cnt_o, e.fc);
        end
    endtask

    // Monitor: compare on each falling edge while expectations are pending
    initial begin
        forever begin
            @(negedge clk_i);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Hard bound on total run time
    initial begin
        repeat (5000) @(posedge clk_i);
        $display("[TB] FAIL watchdog expired with %0d expectations pending", expQ.size());
        $fatal(1, "[TB] watchdog");
    end

    // Stimulus sequence
    initial begin
        logic [3:0] sc;
        rst_i = 1'b0; ID_rs1_i = 5'd1; ID_rs2_i = 5'd2; ID_uses_rs2_i = 1'b1;
        EX_rd_i = 5'd3; EX_MemRead_i = 1'b0; branch_taken_i = 1'b0;
        dmem_req_i = 1'b0; dmem_ack_i = 1'b0;

        // Reset and boot: held for exactly two edges, dmem ignored in BOOT
        idle("rst_a", 1'b0, BUB, 1'b0, 4'd0, 4'd0);
        idle("rst_b", 1'b0, BUB, 1'b0, 4'd0, 4'd0);
        idle("boot_1", 1'b1, BUB, 1'b0, 4'd0, 4'd0);
        memVec("boot_2_dmem_ignored", 1'b1, 1'b0, BUB, 1'b0, 4'd1, 4'd0);
        idle("run_first", 1'b1, NORM, 1'b0, 4'd2, 4'd0);

        // Load-use detection
        applyStimulus("lu_rs2", 1'b1, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, BUB, 1'b0, 4'd2, 4'd0);
        applyStimulus("lu_rs2_unused", 1'b1, 5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 4'd3, 4'd0);
        applyStimulus("lu_rd_zero", 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 4'd3, 4'd0);
        applyStimulus("lu_rs1", 1'b1, 5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, BUB, 1'b0, 4'd3, 4'd0);
        applyStimulus("no_memread", 1'b1, 5'd7, 5'd2, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 4'd4, 4'd0);
        applyStimulus("branch", 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, FLUSH, 1'b0, 4'd4, 4'd0);
        idle("after_branch", 1'b1, NORM, 1'b0, 4'd4, 4'd1);

        // Memory access acked after three frozen cycles
        memVec("mem_wait_1", 1'b1, 1'b0, FRZ, 1'b0, 4'd4, 4'd1);
        memVec("mem_wait_2", 1'b1, 1'b0, FRZ, 1'b0, 4'd5, 4'd1);
        memVec("mem_wait_3", 1'b1, 1'b0, FRZ, 1'b0, 4'd6, 4'd1);
        memVec("mem_ack", 1'b1, 1'b1, NORM, 1'b0, 4'd7, 4'd1);
        memVec("req_ack_in_run", 1'b1, 1'b1, NORM, 1'b0, 4'd7, 4'd1);
        memVec("mem_wait_drop", 1'b1, 1'b0, FRZ, 1'b0, 4'd7, 4'd1);
        idle("req_dropped", 1'b1, NORM, 1'b0, 4'd8, 4'd1);
        idle("run_again", 1'b1, NORM, 1'b0, 4'd8, 4'd1);

        // Freeze beats load-use beats branch; branch is flushed once both clear
        idle("rst2", 1'b0, BUB, 1'b0, 4'd0, 4'd0);
        idle("boot2_1", 1'b1, BUB, 1'b0, 4'd0, 4'd0);
        idle("boot2_2", 1'b1, BUB, 1'b0, 4'd1, 4'd0);
        applyStimulus("all_three_1", 1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, FRZ, 1'b0, 4'd2, 4'd0);
        applyStimulus("all_three_2", 1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, FRZ, 1'b0, 4'd3, 4'd0);
        applyStimulus("lu_after_freeze", 1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, BUB, 1'b0, 4'd4, 4'd0);
        applyStimulus("flush_after_lu", 1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, FLUSH, 1'b0, 4'd5, 4'd0);
        idle("flush_counted", 1'b1, NORM, 1'b0, 4'd5, 4'd1);

        // Timeout: entry cycle, then 64 MEM_WAIT cycles before err_o shows;
        // stall counter saturates at 15 along the way
        memVec("tmo_enter", 1'b1, 1'b0, FRZ, 1'b0, 4'd5, 4'd1);
        for (int j = 2; j <= 67; j++) begin
            sc = (j + 4 > 15) ? 4'd15 : 4'(j + 4);
            memVec($sformatf("tmo_wait_%0d", j), 1'b1, 1'b0, FRZ, (j >= 66) ? 1'b1 : 1'b0, sc, 4'd1);
        end
        memVec("tmo_ack", 1'b1, 1'b1, NORM, 1'b1, 4'd15, 4'd1);
        idle("err_sticky", 1'b1, NORM, 1'b1, 4'd15, 4'd1);

        // Asynchronous reset in the middle of a wait
        memVec("wait_again", 1'b1, 1'b0, FRZ, 1'b1, 4'd15, 4'd1);
        memVec("in_wait", 1'b1, 1'b0, FRZ, 1'b1, 4'd15, 4'd1);
        memVec("async_rst_mid_wait", 1'b0, 1'b0, BUB, 1'b0, 4'd0, 4'd0);
        idle("boot3_1", 1'b1, BUB, 1'b0, 4'd0, 4'd0);
        idle("boot3_2", 1'b1, BUB, 1'b0, 4'd1, 4'd0);
        idle("run3", 1'b1, NORM, 1'b0, 4'd2, 4'd0);

        // Let the monitor drain, bounded
        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk_i);
        #1;
        if (expQ.size() > 0) begin
            missCount++;
            $display("[TB] FAIL drain pending got %0d expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
